// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the requester that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   req_if,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    always_comb begin
        gnt_valid = req_if | req_d;
        gnt_owner = OWN_IF;
        if (req_if && req_d) begin
            gnt_owner = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
        end else if (req_d) begin
            gnt_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// state  | meaning
// IDLE   | no owner
// ACCESS | command on mem_* with mem_en high (1 cycle)
// WAIT   | memory latency countdown (MEM_LAT cycles)
// RESP   | owner's ready pulse; non-owner may be granted back-to-back
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t          state_q, state_d;
    owner_t              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;

    logic                arb_req_if, arb_req_d;
    logic                gnt_valid;
    owner_t              gnt_owner;
    logic                grant;

    // In RESP the owner's req still belongs to the request just completed.
    assign arb_req_if = if_req & ~((state_q == RESP) && (last_grant_q == OWN_IF));
    assign arb_req_d  = d_req  & ~((state_q == RESP) && (last_grant_q == OWN_D));

    rr_arb2 u_rr_arb2 (
        .req_if     (arb_req_if),
        .req_d      (arb_req_d),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    assign grant = gnt_valid && ((state_q == IDLE) || (state_q == RESP));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;

        case (state_q)
            IDLE, RESP: state_d = grant ? ACCESS : IDLE;
            ACCESS: begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                    if (last_grant_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            last_grant_d = gnt_owner;
            mem_en_d     = 1'b1;
            if (gnt_owner == OWN_IF) begin
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wdata_d = '0;
                mem_be_d    = '1;
            end else begin
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_be_d    = d_be;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_D;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

endmodule
